// File: rtl/usb_token_pkg.sv
// rtl/usb_token_pkg.sv - shared PID, state and CRC5 definitions for the USB token transmitter
package usb_token_pkg;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_SOF   = 4'h5;

    // CRC5 x^5+x^2+1 in MSB-first shift form; x^5 term is implicit
    localparam logic [4:0] CRC5_POLY = 5'b00101;
    localparam logic [4:0] CRC5_INIT = 5'b11111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SEND  = 2'd2
    } state_e;

    function automatic logic is_token_pid(input logic [3:0] pid);
        return (pid == PID_OUT) || (pid == PID_IN) || (pid == PID_SETUP) || (pid == PID_SOF);
    endfunction

endpackage

// File: rtl/usb_crc5.sv
// rtl/usb_crc5.sv - combinational USB token CRC5, output already in transmit bit order
module usb_crc5
    import usb_token_pkg::*;
(
    input  logic [10:0] data_i,
    output logic [4:0]  crc_o
);

    logic [4:0] rem;
    logic       fb;

    // Serial LFSR unrolled over the 11 field bits, LSB first as they go on the wire
    always_comb begin
        rem = CRC5_INIT;
        fb  = 1'b0;
        for (int i = 0; i < 11; i++) begin
            fb  = rem[4] ^ data_i[i];
            rem = {rem[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
        end
        crc_o = '0;
        for (int i = 0; i < 5; i++) begin
            crc_o[i] = ~rem[4 - i];
        end
    end

endmodule

// File: rtl/usb_host_token_tx.sv
// rtl/usb_host_token_tx.sv - host token packet builder streaming PID, field and CRC5 bytes to the PHY
module usb_host_token_tx
    import usb_token_pkg::*;
#(
    parameter int READY_TIMEOUT = 1023,
    parameter int TO_W          = 10
) (
    input  logic        clkout2,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_pid,
    input  logic [6:0]  req_addr,
    input  logic [3:0]  req_endp,
    input  logic [10:0] req_frame,
    output logic [7:0]  io_dataOutI,
    output logic        io_txValidI,
    input  logic        io_txReadyO,
    output logic        done,
    output logic        err_timeout,
    output logic        err_badpid
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(READY_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [3:0]      pid_q, pid_d;
    logic [10:0]     field_q, field_d;
    logic [1:0]      idx_q, idx_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic [7:0]      data_q, data_d;
    logic            done_q, done_d;
    logic            err_to_q, err_to_d;
    logic            err_bp_q, err_bp_d;

    logic [4:0] crc5;
    logic [7:0] byte0, byte1, byte2;

    usb_crc5 u_crc5 (
        .data_i (field_q),
        .crc_o  (crc5)
    );

    assign byte0 = {~pid_q, pid_q};
    assign byte1 = field_q[7:0];
    assign byte2 = {crc5, field_q[10:8]};

    // Held low through the done/error pulse so the requester sees completion first
    assign req_ready   = (state_q == IDLE) && !(done_q || err_to_q || err_bp_q);
    assign io_dataOutI = data_q;
    assign io_txValidI = valid_q;
    assign done        = done_q;
    assign err_timeout = err_to_q;
    assign err_badpid  = err_bp_q;

    always_ff @(posedge clkout2) begin
        if (reset) begin
            state_q  <= IDLE;
            pid_q    <= '0;
            field_q  <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
            err_to_q <= 1'b0;
            err_bp_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pid_q    <= pid_d;
            field_q  <= field_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            done_q   <= done_d;
            err_to_q <= err_to_d;
            err_bp_q <= err_bp_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pid_d    = pid_q;
        field_d  = field_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        data_d   = data_q;
        done_d   = 1'b0;
        err_to_d = 1'b0;
        err_bp_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    pid_d   = req_pid;
                    field_d = (req_pid == PID_SOF) ? req_frame : {req_endp, req_addr};
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (is_token_pid(pid_q)) begin
                    state_d = SEND;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    data_d  = byte0;
                end else begin
                    err_bp_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            SEND: begin
                // A ready on the final timeout cycle still counts as a consumed byte
                if (io_txReadyO) begin
                    cnt_d = '0;
                    if (idx_q == 2'd2) begin
                        valid_d = 1'b0;
                        data_d  = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d  = idx_q + 2'd1;
                        data_d = (idx_q == 2'd0) ? byte1 : byte2;
                    end
                end else if (cnt_q == TO_LAST) begin
                    cnt_d    = '0;
                    valid_d  = 1'b0;
                    data_d   = '0;
                    err_to_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_usb_host_token_tx.sv
// tb/tb_usb_host_token_tx.sv - self-checking bench for usb_host_token_tx
module tb_usb_host_token_tx;

    localparam int READY_TIMEOUT = 1023;
    localparam int TO_W          = 10;

    logic        clkout2 = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_pid = '0;
    logic [6:0]  req_addr = '0;
    logic [3:0]  req_endp = '0;
    logic [10:0] req_frame = '0;
    logic [7:0]  io_dataOutI;
    logic        io_txValidI;
    logic        io_txReadyO = 1'b0;
    logic        done;
    logic        err_timeout;
    logic        err_badpid;

    int n_pass  = 0;
    int n_total = 0;

    usb_host_token_tx #(
        .READY_TIMEOUT (READY_TIMEOUT),
        .TO_W          (TO_W)
    ) dut (
        .clkout2     (clkout2),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_pid     (req_pid),
        .req_addr    (req_addr),
        .req_endp    (req_endp),
        .req_frame   (req_frame),
        .io_dataOutI (io_dataOutI),
        .io_txValidI (io_txValidI),
        .io_txReadyO (io_txReadyO),
        .done        (done),
        .err_timeout (err_timeout),
        .err_badpid  (err_badpid)
    );

    always #5 clkout2 = ~clkout2;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  pid;
        logic [6:0]  addr;
        logic [3:0]  endp;
        logic [10:0] frame;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic        bad;
        int          mode;
    } vec_t;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clkout2);
        #1;
    endtask

    // Reflected-register formulation of the USB CRC5; the complemented register is the wire-order CRC
    function automatic logic [4:0] ref_crc5(input logic [10:0] f);
        logic [4:0] r;
        r = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            if (r[0] ^ f[i]) r = (r >> 1) ^ 5'b10100;
            else             r = r >> 1;
        end
        return ~r;
    endfunction

    function automatic logic ref_is_token(input logic [3:0] pid);
        return pid == 4'h1 || pid == 4'h9 || pid == 4'hD || pid == 4'h5;
    endfunction

    task automatic ref_bytes(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp,
                             input logic [10:0] frame, output logic [7:0] b0, output logic [7:0] b1,
                             output logic [7:0] b2);
        logic [10:0] f;
        f  = (pid == 4'h5) ? frame : {endp, addr};
        b0 = {~pid, pid};
        b1 = f[7:0];
        b2 = {ref_crc5(f), f[10:8]};
    endtask

    task automatic drive_req(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp,
                             input logic [10:0] frame);
        int guard;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        chk1("req_ready before accept", req_ready, 1'b1);
        req_valid = 1'b1;
        req_pid   = pid;
        req_addr  = addr;
        req_endp  = endp;
        req_frame = frame;
        tick();
        req_valid = 1'b0;
        req_pid   = 4'($urandom);
        req_addr  = 7'($urandom);
        req_endp  = 4'($urandom);
        req_frame = 11'($urandom);
    endtask

    // Delays give the number of valid cycles without ready before each byte is taken
    task automatic run_pkt(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp,
                           input logic [10:0] frame, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic bad, input int d0, input int d1,
                           input int d2, input logic rdy_hold);
        int k, w;
        int dly[3];
        logic [7:0] eb[3];
        dly[0] = d0; dly[1] = d1; dly[2] = d2;
        eb[0] = e0;  eb[1] = e1;  eb[2] = e2;
        io_txReadyO = rdy_hold;
        drive_req(pid, addr, endp, frame);
        io_txReadyO = rdy_hold ? 1'b1 : 1'($urandom);
        chk1("req_ready in check cycle", req_ready, 1'b0);
        chk1("tx_valid in check cycle", io_txValidI, 1'b0);
        tick();
        if (bad) begin
            chk1("err_badpid pulse", err_badpid, 1'b1);
            chk1("tx_valid after bad pid", io_txValidI, 1'b0);
            chk1("req_ready during badpid pulse", req_ready, 1'b0);
            io_txReadyO = 1'b0;
            tick();
            chk1("err_badpid single cycle", err_badpid, 1'b0);
            chk1("req_ready after badpid", req_ready, 1'b1);
            chk1("tx_valid never after bad pid", io_txValidI, 1'b0);
            return;
        end
        k = 0;
        w = 0;
        while (k < 3) begin
            chk1("tx_valid while sending", io_txValidI, 1'b1);
            chk8($sformatf("byte %0d", k), io_dataOutI, eb[k]);
            chk1("no early done", done, 1'b0);
            io_txReadyO = rdy_hold ? 1'b1 : (w >= dly[k]);
            if (io_txReadyO) begin
                k++;
                w = 0;
            end else begin
                w++;
            end
            tick();
        end
        io_txReadyO = 1'b0;
        chk1("done after third byte", done, 1'b1);
        chk1("tx_valid dropped after third byte", io_txValidI, 1'b0);
        chk1("no timeout on completed packet", err_timeout, 1'b0);
        chk1("req_ready low during done", req_ready, 1'b0);
        tick();
        chk1("done single cycle", done, 1'b0);
        chk1("req_ready after done", req_ready, 1'b1);
    endtask

    vec_t vecs[4];

    initial begin
        logic [7:0] b0, b1, b2;
        logic [3:0] pid;
        int n;
        int bad_data;

        vecs[0] = '{4'hD, 7'd0, 4'd0, 11'h000, 8'h2D, 8'h00, 8'h10, 1'b0, 1};
        vecs[1] = '{4'h9, 7'd1, 4'd0, 11'h7FF, 8'h69, 8'h01, 8'hE8, 1'b0, 0};
        vecs[2] = '{4'h5, 7'd0, 4'd0, 11'h000, 8'hA5, 8'h00, 8'h10, 1'b0, 2};
        vecs[3] = '{4'h3, 7'd9, 4'd2, 11'h123, 8'h00, 8'h00, 8'h00, 1'b1, 1};

        reset = 1'b1;
        tick();
        tick();
        chk1("reset req_ready", req_ready, 1'b1);
        chk1("reset tx_valid", io_txValidI, 1'b0);
        chk8("reset data_out", io_dataOutI, 8'h00);
        chk1("reset done", done, 1'b0);
        chk1("reset err_timeout", err_timeout, 1'b0);
        chk1("reset err_badpid", err_badpid, 1'b0);
        reset = 1'b0;
        tick();

        foreach (vecs[i]) begin
            logic [6:0] a;
            logic [3:0] e;
            a = vecs[i].addr;
            e = vecs[i].endp;
            if (vecs[i].pid == 4'h5) begin
                a = 7'($urandom);
                e = 4'($urandom);
            end
            case (vecs[i].mode)
                0: run_pkt(vecs[i].pid, a, e, vecs[i].frame, vecs[i].b0, vecs[i].b1, vecs[i].b2,
                           vecs[i].bad, 0, 0, 0, 1'b1);
                1: run_pkt(vecs[i].pid, a, e, vecs[i].frame, vecs[i].b0, vecs[i].b1, vecs[i].b2,
                           vecs[i].bad, 1, 1, 1, 1'b0);
                default: run_pkt(vecs[i].pid, a, e, vecs[i].frame, vecs[i].b0, vecs[i].b1, vecs[i].b2,
                                 vecs[i].bad, $urandom_range(0, 3), $urandom_range(0, 3),
                                 $urandom_range(0, 3), 1'b0);
            endcase
        end

        // Withheld ready: byte 0 stays up for exactly READY_TIMEOUT cycles then aborts
        io_txReadyO = 1'b0;
        drive_req(4'h1, 7'h15, 4'h3, 11'h000);
        tick();
        n = 0;
        bad_data = 0;
        while (io_txValidI === 1'b1 && n < READY_TIMEOUT + 5) begin
            if (io_dataOutI !== 8'hE1) bad_data++;
            n++;
            tick();
        end
        chki("valid cycles before timeout", n, READY_TIMEOUT);
        chki("byte0 held during wait", bad_data, 0);
        chk1("err_timeout pulse", err_timeout, 1'b1);
        chk1("no done on timeout", done, 1'b0);
        chk1("req_ready low during timeout pulse", req_ready, 1'b0);
        tick();
        chk1("err_timeout single cycle", err_timeout, 1'b0);
        chk1("req_ready after timeout", req_ready, 1'b1);

        ref_bytes(4'h1, 7'h2A, 4'h7, 11'h0, b0, b1, b2);
        run_pkt(4'h1, 7'h2A, 4'h7, 11'h0, b0, b1, b2, 1'b0, 1, 0, 2, 1'b0);

        // Ready arriving on the last allowed cycle beats the timeout
        ref_bytes(4'h9, 7'h7F, 4'hF, 11'h0, b0, b1, b2);
        run_pkt(4'h9, 7'h7F, 4'hF, 11'h0, b0, b1, b2, 1'b0, READY_TIMEOUT - 1, 0, 2, 1'b0);

        // Reset while byte 1 is pending
        ref_bytes(4'hD, 7'h05, 4'h2, 11'h0, b0, b1, b2);
        io_txReadyO = 1'b0;
        drive_req(4'hD, 7'h05, 4'h2, 11'h0);
        tick();
        chk8("pre-reset byte 0", io_dataOutI, b0);
        io_txReadyO = 1'b1;
        tick();
        io_txReadyO = 1'b0;
        chk8("pre-reset byte 1 pending", io_dataOutI, b1);
        chk1("pre-reset valid", io_txValidI, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk1("mid-packet reset tx_valid", io_txValidI, 1'b0);
        chk1("mid-packet reset req_ready", req_ready, 1'b1);
        chk1("mid-packet reset done", done, 1'b0);
        chk1("mid-packet reset err_timeout", err_timeout, 1'b0);
        tick();
        chk1("post-reset no done", done, 1'b0);
        chk1("post-reset tx_valid", io_txValidI, 1'b0);
        run_pkt(4'hD, 7'h05, 4'h2, 11'h0, b0, b1, b2, 1'b0, 0, 1, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            logic [6:0]  a;
            logic [3:0]  e;
            logic [10:0] f;
            int          r;
            r = $urandom_range(0, 4);
            case (r)
                0: pid = 4'h1;
                1: pid = 4'h9;
                2: pid = 4'hD;
                3: pid = 4'h5;
                default: pid = 4'($urandom);
            endcase
            a = 7'($urandom);
            e = 4'($urandom);
            f = 11'($urandom);
            ref_bytes(pid, a, e, f, b0, b1, b2);
            if ($urandom_range(0, 3) == 0)
                run_pkt(pid, a, e, f, b0, b1, b2, !ref_is_token(pid), 0, 0, 0, 1'b1);
            else
                run_pkt(pid, a, e, f, b0, b1, b2, !ref_is_token(pid), $urandom_range(0, 4),
                        $urandom_range(0, 4), $urandom_range(0, 4), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
